// File: rtl/apb_pwm_capture.sv
// ---------------------------------------------------------------------------
// apb_pwm_capture
//
// APB slave that measures a PWM waveform. The input is synchronised and
// (optionally) glitch filtered. A small FSM then measures the last complete
// high time, the last rise-to-rise period and the number of completed
// periods. A programmable idle timeout detects that the waveform stopped.
//
// Optional feature: define APB_PWM_CAPTURE_GLITCH_FILTER_EN to insert a
// FILTER_LEN-sample glitch filter after the synchroniser.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   psel_i, penable_i,  APB request (paddr_i[4:2] selects the register)
//   pwrite_i, paddr_i,
//   pwdata_i
//   prdata_o, pready_o, registered APB response, valid for one cycle
//   pslverr_o
//   pwm_i               asynchronous PWM waveform to measure
//   irq_o               level interrupt, irq_en & (valid | overflow | timeout)
//
// Register map: 0x00 CTRL, 0x04 STATUS, 0x08 HIGH_TIME, 0x0C PERIOD,
//               0x10 PULSE_COUNT, 0x14 TIMEOUT; indices 6,7 return an error.
// ---------------------------------------------------------------------------
module apb_pwm_capture #(
    parameter int CNT_W      = 24,
    parameter int FILTER_LEN = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [5:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    input  logic        pwm_i,
    output logic        irq_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [31:0]      ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HIGH, ST_LOW} state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    if (CNT_W < 2 || CNT_W > 32 || FILTER_LEN < 1) begin : g_bad_cfg
        $error("apb_pwm_capture: CNT_W must be 2..32 and FILTER_LEN >= 1");
    end

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_sync2, r_lvl_d;
    logic             w_lvl, w_rise, w_fall;
    logic             r_enable, r_irq_en, r_meas_valid, r_ovf, r_tmo, r_irq;
    logic [CNT_W-1:0] r_period_cnt, r_high_cnt, r_high_time, r_period;
    logic [CNT_W-1:0] r_pulse_cnt, r_tmo_lim;
    logic [CNT_W-1:0] w_period_nxt, w_high_nxt;
    logic             w_lat_high, w_lat_per, w_set_valid, w_set_ovf, w_set_tmo, w_tmo_hit;
    logic             r_pready, r_pslverr;
    logic [31:0]      r_prdata, w_rdata;
    logic [2:0]       w_idx;
    logic             w_xfer, w_bad_idx, w_wr, w_wr_ctrl, w_wr_stat, w_wr_tmo, w_clear;
    logic             w_unused;

    assign w_unused = &{1'b0, paddr_i[5], paddr_i[1:0], pwdata_i};

    // Input path: two-flop synchroniser, optional filter, edge-detect flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync1 <= pwm_i;
            r_sync2 <= r_sync1;
            r_lvl_d <= w_lvl;
        end
    end

`ifdef APB_PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int              FILT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [FILT_W-1:0] FILT_ONE  = FILT_W'(1);

    logic              r_filt;
    logic [FILT_W-1:0] r_filt_cnt;

    // The filtered level follows only after FILTER_LEN consecutive samples
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_filt     <= 1'b0;
            r_filt_cnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FILT_LAST) begin
            r_filt     <= r_sync2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FILT_ONE;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_rise = w_lvl & ~r_lvl_d;
    assign w_fall = ~w_lvl & r_lvl_d;

    // APB decode. r_pready blocks a held request from re-triggering.
    assign w_idx     = paddr_i[4:2];
    assign w_bad_idx = (w_idx >= 3'd6);
    assign w_xfer    = psel_i & penable_i & ~r_pready;
    assign w_wr      = w_xfer & pwrite_i & ~w_bad_idx;
    assign w_wr_ctrl = w_wr & (w_idx == 3'd0);
    assign w_wr_stat = w_wr & (w_idx == 3'd1);
    assign w_wr_tmo  = w_wr & (w_idx == 3'd5);
    assign w_clear   = w_wr_ctrl & pwdata_i[2];

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            3'd0:    w_rdata = {30'd0, r_irq_en, r_enable};
            3'd1:    w_rdata = {28'd0, w_lvl, r_tmo, r_ovf, r_meas_valid};
            3'd2:    w_rdata = 32'(r_high_time);
            3'd3:    w_rdata = 32'(r_period);
            3'd4:    w_rdata = 32'(r_pulse_cnt);
            3'd5:    w_rdata = 32'(r_tmo_lim);
            default: w_rdata = ERR_DATA;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period_cnt;
        w_high_nxt   = r_high_cnt;
        w_lat_high   = 1'b0;
        w_lat_per    = 1'b0;
        w_set_valid  = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_tmo    = 1'b0;
        w_tmo_hit    = (r_tmo_lim != '0) && (r_period_cnt == r_tmo_lim);
        case (r_state)
            ST_IDLE: if (r_enable) w_state_nxt = ST_ARM;
            ST_ARM: begin
                // Waiting for the first clean rise; a pulse already in progress is skipped.
                if (w_rise) begin
                    w_period_nxt = CNT_ONE;
                    w_high_nxt   = CNT_ONE;
                    w_state_nxt  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tmo_hit) begin
                    w_set_tmo   = 1'b1;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_period_nxt = sat_inc(r_period_cnt);
                    if (w_fall) begin
                        w_lat_high  = 1'b1;
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_high_nxt = sat_inc(r_high_cnt);
                    end
                    w_set_ovf = (w_period_nxt == CNT_MAX) || (w_high_nxt == CNT_MAX);
                end
            end
            ST_LOW: begin
                if (w_tmo_hit) begin
                    w_set_tmo   = 1'b1;
                    w_state_nxt = ST_ARM;
                end else if (w_rise) begin
                    w_lat_per    = 1'b1;
                    w_set_valid  = 1'b1;
                    w_period_nxt = CNT_ONE;
                    w_high_nxt   = CNT_ONE;
                    w_state_nxt  = ST_HIGH;
                    w_set_ovf    = (sat_inc(r_pulse_cnt) == CNT_MAX);
                end else begin
                    w_period_nxt = sat_inc(r_period_cnt);
                    w_set_ovf    = (w_period_nxt == CNT_MAX);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Disabling parks the FSM but keeps every measured value.
        if (!r_enable && (r_state != ST_IDLE)) begin
            w_state_nxt  = ST_IDLE;
            w_period_nxt = r_period_cnt;
            w_high_nxt   = r_high_cnt;
            w_lat_high   = 1'b0;
            w_lat_per    = 1'b0;
            w_set_valid  = 1'b0;
            w_set_ovf    = 1'b0;
            w_set_tmo    = 1'b0;
        end
        // A clear command overrides any edge seen in the same cycle.
        if (w_clear) begin
            w_state_nxt  = pwdata_i[0] ? ST_ARM : ST_IDLE;
            w_period_nxt = '0;
            w_high_nxt   = '0;
            w_lat_high   = 1'b0;
            w_lat_per    = 1'b0;
            w_set_valid  = 1'b0;
            w_set_ovf    = 1'b0;
            w_set_tmo    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_period_cnt <= '0;
            r_high_cnt   <= '0;
            r_high_time  <= '0;
            r_period     <= '0;
            r_pulse_cnt  <= '0;
            r_tmo_lim    <= '0;
            r_enable     <= 1'b0;
            r_irq_en     <= 1'b0;
            r_meas_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_tmo        <= 1'b0;
            r_irq        <= 1'b0;
            r_pready     <= 1'b0;
            r_pslverr    <= 1'b0;
            r_prdata     <= '0;
        end else begin
            r_period_cnt <= w_period_nxt;
            r_high_cnt   <= w_high_nxt;
            if (w_lat_high) r_high_time <= r_high_cnt;
            if (w_lat_per)  r_period    <= r_period_cnt;
            if (w_clear)        r_pulse_cnt <= '0;
            else if (w_lat_per) r_pulse_cnt <= sat_inc(r_pulse_cnt);
            if (w_wr_ctrl) begin
                r_enable <= pwdata_i[0];
                r_irq_en <= pwdata_i[1];
            end
            if (w_wr_tmo) r_tmo_lim <= pwdata_i[CNT_W-1:0];
            // Flag priority: clear command, then hardware set, then W1C.
            if (w_clear)                      r_meas_valid <= 1'b0;
            else if (w_set_valid)             r_meas_valid <= 1'b1;
            else if (w_wr_stat && pwdata_i[0]) r_meas_valid <= 1'b0;
            if (w_clear)                      r_ovf <= 1'b0;
            else if (w_set_ovf)               r_ovf <= 1'b1;
            else if (w_wr_stat && pwdata_i[1]) r_ovf <= 1'b0;
            if (w_clear)                      r_tmo <= 1'b0;
            else if (w_set_tmo)               r_tmo <= 1'b1;
            else if (w_wr_stat && pwdata_i[2]) r_tmo <= 1'b0;
            r_irq     <= r_irq_en & (r_meas_valid | r_ovf | r_tmo);
            r_pready  <= w_xfer;
            r_pslverr <= w_xfer & w_bad_idx;
            r_prdata  <= (w_xfer && (!pwrite_i || w_bad_idx)) ? w_rdata : '0;
        end
    end

    assign prdata_o  = r_prdata;
    assign pready_o  = r_pready;
    assign pslverr_o = r_pslverr;
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_apb_pwm_capture.sv
`timescale 1ns/1ps
module tb_apb_pwm_capture;

    localparam int CW   = 8;
    localparam int FL   = 4;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [5:0] A_CTRL = 6'h00;
    localparam logic [5:0] A_STAT = 6'h04;
    localparam logic [5:0] A_HT   = 6'h08;
    localparam logic [5:0] A_PER  = 6'h0C;
    localparam logic [5:0] A_CNT  = 6'h10;
    localparam logic [5:0] A_TMO  = 6'h14;
    localparam logic [5:0] A_IDX6 = 6'h18;
    localparam logic [5:0] A_IDX7 = 6'h1C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [5:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        pwm = 1'b0;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    int q_h[$];
    int q_l[$];

    apb_pwm_capture #(.CNT_W(CW), .FILTER_LEN(FL)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .psel_i   (psel),
        .penable_i(penable),
        .pwrite_i (pwrite),
        .paddr_i  (paddr),
        .pwdata_i (pwdata),
        .prdata_o (prdata),
        .pready_o (pready),
        .pslverr_o(pslverr),
        .pwm_i    (pwm),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One APB transfer; the request is held through the ready cycle so a
    // second, spurious ready would be caught.
    task automatic apb_xfer(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                            output logic [31:0] rd_data, output logic err);
        int n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!pready && n < 8);
        chk_eq("pready", 32'(pready), 32'd1);
        rd_data = prdata;
        err     = pslverr;
        @(posedge clk); #1;
        chk_eq("single_pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] rdd;
        logic        e;
        apb_xfer(1'b1, a, d, rdd, e);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b0, a, 32'd0, d, e);
        chk_eq(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_pwm(input logic lvl, input int cyc);
        pwm = lvl;
        repeat (cyc) begin @(posedge clk); #1; end
    endtask

    task automatic play_seq();
        for (int i = 0; i < q_h.size(); i++) begin
            drive_pwm(1'b1, q_h[i]);
            drive_pwm(1'b0, q_l[i]);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Reference: the waveform is a list of (high, low) pulses starting from
    // low. The first rise only arms; each later rise completes one period.
    // With the filter, pulses shorter than FL vanish into the preceding low.
    task automatic model_expect(output int e_cnt, output int e_per, output int e_ht);
        int h[$];
        int l[$];
        bit absorb;
        int n;
        for (int i = 0; i < q_h.size(); i++) begin
            absorb = 1'b0;
`ifdef APB_PWM_CAPTURE_GLITCH_FILTER_EN
            absorb = (q_h[i] < FL) && (h.size() > 0);
`endif
            if (absorb) begin
                l[l.size()-1] = l[l.size()-1] + q_h[i] + q_l[i];
            end else begin
                h.push_back(q_h[i]);
                l.push_back(q_l[i]);
            end
        end
        n     = h.size();
        e_cnt = n - 1;
        e_per = sat(h[n-2] + l[n-2]);
        e_ht  = sat(h[n-1]);
    endtask

    task automatic model_check(input string tag, input int exp_status);
        int e_cnt, e_per, e_ht;
        model_expect(e_cnt, e_per, e_ht);
        rd_chk({tag, "_status"}, A_STAT, 32'(exp_status));
        rd_chk({tag, "_count"}, A_CNT, 32'(e_cnt));
        rd_chk({tag, "_period"}, A_PER, 32'(e_per));
        rd_chk({tag, "_high"}, A_HT, 32'(e_ht));
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] rv;

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        chk_eq("rst_prdata", prdata, 32'd0);
        chk_eq("rst_pready", 32'(pready), 32'd0);
        chk_eq("rst_pslverr", 32'(pslverr), 32'd0);
        chk_eq("rst_irq", 32'(irq), 32'd0);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);
        rd_chk("rst_status", A_STAT, 32'd0);
        rd_chk("rst_high", A_HT, 32'd0);
        rd_chk("rst_period", A_PER, 32'd0);
        rd_chk("rst_count", A_CNT, 32'd0);
        rd_chk("rst_timeout", A_TMO, 32'd0);

        apb_xfer(1'b0, A_IDX7, 32'd0, d, e);
        chk_eq("idx7_data", d, 32'hDEADBEEF);
        chk_eq("idx7_err", 32'(e), 32'd1);
        apb_xfer(1'b1, A_IDX6, 32'h1234, d, e);
        chk_eq("idx6_wr_err", 32'(e), 32'd1);
        chk_eq("idx6_wr_data", d, 32'hDEADBEEF);
        apb_xfer(1'b0, A_CTRL, 32'd0, d, e);
        chk_eq("good_no_err", 32'(e), 32'd0);

        wr(A_CTRL, 32'd7);
        rd_chk("ctrl_rb", A_CTRL, 32'd3);
        rv = $urandom;
        wr(A_TMO, rv);
        rd_chk("tmo_rb", A_TMO, rv & 32'(CMAX));
        wr(A_TMO, 32'd0);

        // Basic 20/80 waveform, three periods.
        wr(A_CTRL, 32'd5);
        idle(10);
        q_h = '{20, 20, 20};
        q_l = '{80, 80, 80};
        play_seq();
        model_check("basic", 1);

        // Idle timeout and interrupt behaviour.
        wr(A_TMO, 32'd150);
        wr(A_CTRL, 32'd7);
        idle(5);
        drive_pwm(1'b1, 20); drive_pwm(1'b0, 80);
        drive_pwm(1'b1, 20); drive_pwm(1'b0, 100);
        rd_chk("tmo_early", A_STAT, 32'd1);
        drive_pwm(1'b0, 100);
        rd_chk("tmo_set", A_STAT, 32'd5);
        chk_eq("tmo_irq", 32'(irq), 32'd1);
        rd_chk("tmo_period", A_PER, 32'd100);
        rd_chk("tmo_count", A_CNT, 32'd1);
        wr(A_STAT, 32'd4);
        idle(2);
        rd_chk("tmo_w1c", A_STAT, 32'd1);
        chk_eq("irq_valid_only", 32'(irq), 32'd1);
        wr(A_STAT, 32'd1);
        idle(2);
        chk_eq("irq_cleared", 32'(irq), 32'd0);
        rd_chk("stat_clear", A_STAT, 32'd0);
        wr(A_TMO, 32'd0);

        // Stuck-high input saturates the counters.
        wr(A_CTRL, 32'd5);
        idle(5);
        drive_pwm(1'b1, 400); drive_pwm(1'b0, 10);
        rd_chk("ovf_high", A_HT, 32'(CMAX));
        rd_chk("ovf_status", A_STAT, 32'd2);
        drive_pwm(1'b1, 5); drive_pwm(1'b0, 10);
        rd_chk("ovf_period", A_PER, 32'(CMAX));
        rd_chk("ovf_count", A_CNT, 32'd1);
        rd_chk("ovf_high2", A_HT, 32'd5);
        rd_chk("ovf_status2", A_STAT, 32'd3);

        // Enable while the input is already high: the partial pulse is skipped.
        wr(A_CTRL, 32'd0);
        drive_pwm(1'b1, 10);
        wr(A_CTRL, 32'd5);
        rd_chk("level_high", A_STAT, 32'd8);
        drive_pwm(1'b1, 2); drive_pwm(1'b0, 10);
        drive_pwm(1'b1, 10); drive_pwm(1'b0, 10);
        drive_pwm(1'b1, 10); drive_pwm(1'b0, 10);
        rd_chk("part_count", A_CNT, 32'd1);
        rd_chk("part_period", A_PER, 32'd20);
        rd_chk("part_high", A_HT, 32'd10);
        wr(A_CTRL, 32'd5);
        rd_chk("clr_count", A_CNT, 32'd0);
        rd_chk("clr_status", A_STAT, 32'd0);
        rd_chk("clr_period_kept", A_PER, 32'd20);

        // 30/70 waveform with a 2-cycle glitch inside the low phase.
        idle(5);
        q_h = '{30, 2, 30};
        q_l = '{30, 38, 20};
        play_seq();
        model_check("glitch", 1);

        // Randomised pulse trains.
        for (int it = 0; it < 12; it++) begin
            int n;
            wr(A_CTRL, 32'd5);
            idle(5);
            n = int'($urandom_range(2, 5));
            q_h.delete();
            q_l.delete();
            for (int k = 0; k < n; k++) begin
                q_h.push_back(int'($urandom_range(5, 100)));
                q_l.push_back(int'($urandom_range(5, 100)));
            end
            play_seq();
            drive_pwm(1'b0, 5);
            model_check("rand", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
